// File: rtl/flunky_mailbox_if.sv
// Bus bundle for flunky_mailbox: the APB slave port toward the HPS, the PicoRV32
// native memory port and the two doorbell lines.
// The mailbox connects to the slave modport and the bus owner connects to the master modport.
interface flunky_mailbox_if #(
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [3:0]        paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  logic              rv_sel;
  logic              mem_valid;
  logic [3:0]        mem_addr;
  logic [3:0]        mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              irq_hps;
  logic              irq_rv;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr,
    input  rv_sel, mem_valid, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata,
    output irq_hps, irq_rv
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr,
    output rv_sel, mem_valid, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata,
    input  irq_hps, irq_rv
  );
endinterface

// File: rtl/flunky_mailbox.sv
// flunky_mailbox: bidirectional message mailbox between the HPS (APB) and the
// PicoRV32 (native memory bus). FIFO 0 is h2r (HPS pushes, RISC-V pops) and
// FIFO 1 is r2h (RISC-V pushes, HPS pops). Each side sees the same four word
// registers: TX, RX, STATUS and IRQ_EN.
// Define MAILBOX_IRQ_EN to build the IRQ_EN registers and the doorbell interrupts.
// Without that define, IRQ_EN reads as 0 and both irq lines are tied low.
module flunky_mailbox #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             resetn,
  flunky_mailbox_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // APB side decode. The access cycle is psel & penable, with zero wait states.
  logic       w_apbAcc;
  logic [1:0] w_apbIdx;
  logic       w_hpsPush;
  logic       w_hpsPop;
  logic       w_hpsStatWr;

  assign w_apbAcc    = bus.psel & bus.penable;
  assign w_apbIdx    = bus.paddr[3:2];
  assign w_hpsPush   = w_apbAcc &  bus.pwrite & (w_apbIdx == 2'd0);
  assign w_hpsPop    = w_apbAcc & ~bus.pwrite & (w_apbIdx == 2'd1);
  assign w_hpsStatWr = w_apbAcc &  bus.pwrite & (w_apbIdx == 2'd2);

  // CPU side decode. The mem_ready gate blocks a second accept while the CPU holds valid.
  logic       r_memReady;
  logic [DATA_W-1:0] r_memRdata;
  logic       w_rvAcc;
  logic       w_rvWr;
  logic [1:0] w_rvIdx;
  logic       w_rvPush;
  logic       w_rvPop;
  logic       w_rvStatWr;

  assign w_rvAcc    = bus.mem_valid & bus.rv_sel & ~r_memReady;
  assign w_rvWr     = |bus.mem_wstrb;
  assign w_rvIdx    = bus.mem_addr[3:2];
  assign w_rvPush   = w_rvAcc &  w_rvWr & (w_rvIdx == 2'd0);
  assign w_rvPop    = w_rvAcc & ~w_rvWr & (w_rvIdx == 2'd1);
  assign w_rvStatWr = w_rvAcc &  w_rvWr & (w_rvIdx == 2'd2);

  // FIFO storage. Index 0 is h2r and index 1 is r2h.
  logic [DATA_W-1:0] r_mem [2][DEPTH];
  logic [AW-1:0]     r_wp  [2];
  logic [AW-1:0]     r_rp  [2];
  logic [CW-1:0]     r_cnt [2];
  logic [DATA_W-1:0] w_wdata [2];
  logic [DATA_W-1:0] w_head  [2];
  logic [1:0] w_push, w_pop, w_full, w_empty, w_popOk, w_pushOk, w_ovf, w_unf;

  assign w_push     = {w_rvPush, w_hpsPush};
  assign w_pop      = {w_hpsPop, w_rvPop};
  assign w_wdata[0] = bus.pwdata;
  assign w_wdata[1] = bus.mem_wdata;

  // A pop on a full FIFO frees a slot for a push on the same edge. A pop on an
  // empty FIFO always underflows, because a push is never bypassed to the reader.
  always_comb begin
    for (int f = 0; f < 2; f++) begin
      w_full[f]   = (r_cnt[f] == CW'(DEPTH));
      w_empty[f]  = (r_cnt[f] == '0);
      w_popOk[f]  = w_pop[f] & ~w_empty[f];
      w_pushOk[f] = w_push[f] & (~w_full[f] | w_popOk[f]);
      w_ovf[f]    = w_push[f] & ~w_pushOk[f];
      w_unf[f]    = w_pop[f] & w_empty[f];
      w_head[f]   = r_mem[f][r_rp[f]];
    end
  end

  // Update the FIFO pointers, counts and data. The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int f = 0; f < 2; f++) begin
        for (int i = 0; i < DEPTH; i++) r_mem[f][i] <= '0;
        r_wp[f]  <= '0;
        r_rp[f]  <= '0;
        r_cnt[f] <= '0;
      end
    end else begin
      for (int f = 0; f < 2; f++) begin
        if (w_pushOk[f]) begin
          r_mem[f][r_wp[f]] <= w_wdata[f];
          r_wp[f]           <= r_wp[f] + 1'b1;
        end
        if (w_popOk[f]) r_rp[f] <= r_rp[f] + 1'b1;
        case ({w_pushOk[f], w_popOk[f]})
          2'b10:   r_cnt[f] <= r_cnt[f] + 1'b1;
          2'b01:   r_cnt[f] <= r_cnt[f] - 1'b1;
          default: r_cnt[f] <= r_cnt[f];
        endcase
      end
    end
  end

  // Sticky error flags for each side. A new error wins over a write-1-to-clear in the same cycle.
  logic r_hpsOvf, r_hpsUnf, r_rvOvf, r_rvUnf;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hpsOvf <= 1'b0;
      r_hpsUnf <= 1'b0;
      r_rvOvf  <= 1'b0;
      r_rvUnf  <= 1'b0;
    end else begin
      r_hpsOvf <= w_ovf[0] | (r_hpsOvf & ~(w_hpsStatWr & bus.pwdata[4]));
      r_hpsUnf <= w_unf[1] | (r_hpsUnf & ~(w_hpsStatWr & bus.pwdata[5]));
      r_rvOvf  <= w_ovf[1] | (r_rvOvf  & ~(w_rvStatWr  & bus.mem_wdata[4]));
      r_rvUnf  <= w_unf[0] | (r_rvUnf  & ~(w_rvStatWr  & bus.mem_wdata[5]));
    end
  end

  // Each side reads a STATUS view in which its own outgoing FIFO is "tx".
  logic [31:0] w_hpsStatus;
  logic [31:0] w_rvStatus;
  logic        w_hpsIrqEn;
  logic        w_rvIrqEn;

  assign w_hpsStatus = {8'h00, 8'(r_cnt[1]), 8'(r_cnt[0]), 2'b00, r_hpsUnf, r_hpsOvf,
                        w_empty[1], w_full[1], w_empty[0], w_full[0]};
  assign w_rvStatus  = {8'h00, 8'(r_cnt[0]), 8'(r_cnt[1]), 2'b00, r_rvUnf, r_rvOvf,
                        w_empty[0], w_full[0], w_empty[1], w_full[1]};

  // Combinational APB read data and error response. Both are valid only during the access cycle.
  logic [DATA_W-1:0] w_prdata;
  always_comb begin
    w_prdata = '0;
    if (w_apbAcc && !bus.pwrite) begin
      case (w_apbIdx)
        2'd1:    w_prdata = w_empty[1] ? '0 : w_head[1];
        2'd2:    w_prdata = w_hpsStatus;
        2'd3:    w_prdata = {31'b0, w_hpsIrqEn};
        default: w_prdata = '0;
      endcase
    end
  end

  assign bus.prdata  = w_prdata;
  assign bus.pready  = 1'b1;
  assign bus.pslverr = w_ovf[0] | w_unf[1];

  // CPU read mux. It is sampled into mem_rdata on the edge that accepts the read.
  logic [DATA_W-1:0] w_rvRdata;
  always_comb begin
    w_rvRdata = '0;
    case (w_rvIdx)
      2'd1:    w_rvRdata = w_empty[0] ? '0 : w_head[0];
      2'd2:    w_rvRdata = w_rvStatus;
      2'd3:    w_rvRdata = {31'b0, w_rvIrqEn};
      default: w_rvRdata = '0;
    endcase
  end

  // One-cycle mem_ready pulse per accepted transaction. Read data holds until the next accepted read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_memReady <= 1'b0;
      r_memRdata <= '0;
    end else begin
      r_memReady <= w_rvAcc;
      if (w_rvAcc && !w_rvWr) r_memRdata <= w_rvRdata;
    end
  end

  assign bus.mem_ready = r_memReady;
  assign bus.mem_rdata = r_memRdata;

`ifdef MAILBOX_IRQ_EN
  logic w_hpsIrqWr, w_rvIrqWr;
  logic r_hpsIrqEn, r_rvIrqEn, r_irqHps, r_irqRv;

  assign w_hpsIrqWr = w_apbAcc & bus.pwrite & (w_apbIdx == 2'd3);
  assign w_rvIrqWr  = w_rvAcc  & w_rvWr     & (w_rvIdx  == 2'd3);

  // Doorbell enables, plus level interrupts registered from the state of each side's inbound FIFO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hpsIrqEn <= 1'b0;
      r_rvIrqEn  <= 1'b0;
      r_irqHps   <= 1'b0;
      r_irqRv    <= 1'b0;
    end else begin
      if (w_hpsIrqWr) r_hpsIrqEn <= bus.pwdata[0];
      if (w_rvIrqWr)  r_rvIrqEn  <= bus.mem_wdata[0];
      r_irqHps <= r_hpsIrqEn & ~w_empty[1];
      r_irqRv  <= r_rvIrqEn  & ~w_empty[0];
    end
  end

  assign w_hpsIrqEn  = r_hpsIrqEn;
  assign w_rvIrqEn   = r_rvIrqEn;
  assign bus.irq_hps = r_irqHps;
  assign bus.irq_rv  = r_irqRv;
`else
  assign w_hpsIrqEn  = 1'b0;
  assign w_rvIrqEn   = 1'b0;
  assign bus.irq_hps = 1'b0;
  assign bus.irq_rv  = 1'b0;
`endif

  // The decode ignores the byte-offset bits of both addresses.
  logic w_unused;
  assign w_unused = ^{bus.paddr[1:0], bus.mem_addr[1:0]};
endmodule

// File: tb/tb_flunky_mailbox.sv
// Testbench for flunky_mailbox. A table of register accesses drives the design.
// A queue per FIFO acts as a scoreboard for RX data. Hand-written sequences
// cover the same-edge push/pop case, the doorbells and reset during a transaction.
module tb_flunky_mailbox;
  localparam int DEPTH = 8;
`ifdef MAILBOX_IRQ_EN
  localparam logic IRQV = 1'b1;
`else
  localparam logic IRQV = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;

  flunky_mailbox_if #(.DATA_W(32)) bus ();

  flunky_mailbox #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rvSide;
    bit          wr;
    logic [1:0]  idx;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] expData;
    bit          expErr;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] h2rQ[$];
  logic [31:0] r2hQ[$];
  int          nChecks = 0;
  int          nErrors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void addVec(bit rvSide, bit wr, logic [1:0] idx, logic [31:0] wdata,
                                 logic [3:0] strb, logic [31:0] expData, bit expErr, string name);
    vec_t v;
    v.rvSide  = rvSide;
    v.wr      = wr;
    v.idx     = idx;
    v.wdata   = wdata;
    v.strb    = strb;
    v.expData = expData;
    v.expErr  = expErr;
    v.name    = name;
    vecs.push_back(v);
  endfunction

  task automatic apbXfer(input bit wr, input logic [3:0] addr, input logic [31:0] d,
                         output logic [31:0] rd, output logic err);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = d;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(negedge clk);
    rd  = bus.prdata;
    err = bus.pslverr;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic rvXfer(input bit wr, input logic [1:0] idx, input logic [31:0] d,
                        input logic [3:0] strb, input string name, output logic [31:0] rd);
    bit seen = 1'b0;
    @(posedge clk); #1;
    bus.mem_valid = 1'b1; bus.rv_sel = 1'b1; bus.mem_addr = {idx, 2'b00};
    bus.mem_wstrb = wr ? strb : 4'h0; bus.mem_wdata = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.mem_ready) begin
        seen = 1'b1;
        break;
      end
    end
    rd = bus.mem_rdata;
    checkOutput({name, " ready"}, {31'b0, seen}, 32'd1);
    @(posedge clk); #1;
    bus.mem_valid = 1'b0; bus.rv_sel = 1'b0; bus.mem_wstrb = 4'h0;
    @(negedge clk);
    checkOutput({name, " ready pulse"}, {31'b0, bus.mem_ready}, 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] rd;
    logic [31:0] exp;
    logic        err;
    exp = v.expData;
    if (v.wr && v.idx == 2'd0) begin
      if (v.rvSide) begin
        if (r2hQ.size() < DEPTH) r2hQ.push_back(v.wdata);
      end else begin
        if (h2rQ.size() < DEPTH) h2rQ.push_back(v.wdata);
      end
    end
    if (!v.wr && v.idx == 2'd1) begin
      if (v.rvSide) exp = (h2rQ.size() > 0) ? h2rQ.pop_front() : 32'h0;
      else          exp = (r2hQ.size() > 0) ? r2hQ.pop_front() : 32'h0;
    end
    if (v.rvSide) begin
      rvXfer(v.wr, v.idx, v.wdata, v.strb, v.name, rd);
    end else begin
      apbXfer(v.wr, {v.idx, 2'b00}, v.wdata, rd, err);
      checkOutput({v.name, " pslverr"}, {31'b0, err}, {31'b0, v.expErr});
    end
    if (!v.wr) checkOutput({v.name, " data"}, rd, exp);
  endtask

  task automatic runTable();
    foreach (vecs[i]) applyStimulus(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    #200000;
    nErrors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] exp;
    logic        err;

    resetn = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
    bus.rv_sel = 1'b0; bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_wstrb = '0; bus.mem_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset mem_ready", {31'b0, bus.mem_ready}, 32'd0);
    checkOutput("reset mem_rdata", bus.mem_rdata, 32'd0);
    checkOutput("reset pslverr", {31'b0, bus.pslverr}, 32'd0);
    checkOutput("reset pready", {31'b0, bus.pready}, 32'd1);
    checkOutput("reset irq_hps", {31'b0, bus.irq_hps}, 32'd0);
    checkOutput("reset irq_rv", {31'b0, bus.irq_rv}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Status after reset, then HPS to RISC-V traffic ending in an underflow.
    addVec(0, 0, 2, 0, 4'h0, 32'h0000_000A, 0, "hps status reset");
    addVec(1, 0, 2, 0, 4'h0, 32'h0000_000A, 0, "rv status reset");
    addVec(0, 0, 3, 0, 4'h0, 32'h0, 0, "hps irqen reset");
    addVec(0, 1, 0, 32'hDEAD_0001, 4'h0, 0, 0, "hps push 1");
    addVec(0, 1, 0, 32'hDEAD_0002, 4'h0, 0, 0, "hps push 2");
    addVec(0, 1, 0, 32'hDEAD_0003, 4'h0, 0, 0, "hps push 3");
    addVec(1, 0, 2, 0, 4'h0, 32'h0003_0002, 0, "rv status 3 in");
    addVec(0, 0, 2, 0, 4'h0, 32'h0000_0308, 0, "hps status 3 out");
    for (int i = 1; i <= 4; i++) addVec(1, 0, 1, 0, 4'h0, 0, 0, $sformatf("rv pop %0d", i));
    addVec(1, 0, 2, 0, 4'h0, 32'h0000_002A, 0, "rv status underflow");
    addVec(0, 1, 1, 32'h1234_5678, 4'h0, 0, 0, "hps write rx");
    addVec(0, 0, 0, 0, 4'h0, 32'h0, 0, "hps read tx");
    addVec(0, 0, 2, 0, 4'h0, 32'h0000_000A, 0, "hps status clean");
    // RISC-V to HPS traffic: overflow, drain and underflow, then clear the sticky flags.
    for (int i = 1; i <= 8; i++)
      addVec(1, 1, 0, 32'hC0DE_0000 + i, (i == 3) ? 4'b0001 : 4'hF, 0, 0, $sformatf("rv push %0d", i));
    addVec(1, 0, 2, 0, 4'h0, 32'h0000_0829, 0, "rv status full");
    addVec(1, 1, 0, 32'hC0DE_0009, 4'hF, 0, 0, "rv push 9");
    addVec(1, 0, 2, 0, 4'h0, 32'h0000_0839, 0, "rv status overflow");
    addVec(0, 0, 2, 0, 4'h0, 32'h0008_0006, 0, "hps status full");
    for (int i = 1; i <= 8; i++) addVec(0, 0, 1, 0, 4'h0, 0, 0, $sformatf("hps pop %0d", i));
    addVec(0, 0, 1, 0, 4'h0, 0, 1, "hps pop 9");
    addVec(0, 0, 2, 0, 4'h0, 32'h0000_002A, 0, "hps status underflow");
    addVec(0, 1, 2, 32'h30, 4'h0, 0, 0, "hps clear sticky");
    addVec(0, 0, 2, 0, 4'h0, 32'h0000_000A, 0, "hps status cleared");
    addVec(1, 0, 2, 0, 4'h0, 32'h0000_003A, 0, "rv status sticky");
    addVec(1, 1, 2, 32'h30, 4'hF, 0, 0, "rv clear sticky");
    addVec(1, 0, 2, 0, 4'h0, 32'h0000_000A, 0, "rv status cleared");
    for (int i = 1; i <= 8; i++)
      addVec(1, 1, 0, 32'hA000_0000 + i, 4'hF, 0, 0, $sformatf("rv fill %0d", i));
    runTable();

    // HPS pop and CPU push hit the full r2h FIFO on the same edge.
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 4'h4;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    bus.mem_valid = 1'b1; bus.rv_sel = 1'b1; bus.mem_addr = 4'h0; bus.mem_wstrb = 4'hF;
    bus.mem_wdata = 32'hA000_0009;
    exp = r2hQ.pop_front();
    r2hQ.push_back(32'hA000_0009);
    @(negedge clk);
    checkOutput("simul pop data", bus.prdata, exp);
    checkOutput("simul pslverr", {31'b0, bus.pslverr}, 32'd0);
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge clk);
    checkOutput("simul ready", {31'b0, bus.mem_ready}, 32'd1);
    @(posedge clk); #1;
    bus.mem_valid = 1'b0; bus.rv_sel = 1'b0; bus.mem_wstrb = 4'h0;
    addVec(0, 0, 2, 0, 4'h0, 32'h0008_0006, 0, "simul hps status");
    addVec(1, 0, 2, 0, 4'h0, 32'h0000_0809, 0, "simul rv status");
    for (int i = 1; i <= 8; i++) addVec(0, 0, 1, 0, 4'h0, 0, 0, $sformatf("simul drain %0d", i));
    addVec(0, 0, 2, 0, 4'h0, 32'h0000_000A, 0, "simul hps empty");
    addVec(1, 1, 3, 32'h1, 4'hF, 0, 0, "rv irqen set");
    addVec(1, 0, 3, 0, 4'h0, {31'b0, IRQV}, 0, "rv irqen read");
    runTable();

    // RISC-V doorbell: rises one cycle after the push and drops after the CPU pops.
    h2rQ.push_back(32'h1111_0001);
    apbXfer(1'b1, 4'h0, 32'h1111_0001, rd, err);
    @(negedge clk);
    checkOutput("irq_rv latency", {31'b0, bus.irq_rv}, 32'd0);
    @(negedge clk);
    checkOutput("irq_rv rise", {31'b0, bus.irq_rv}, {31'b0, IRQV});
    checkOutput("irq_hps idle", {31'b0, bus.irq_hps}, 32'd0);
    addVec(1, 0, 1, 0, 4'h0, 0, 0, "rv pop irq word");
    runTable();
    checkOutput("irq_rv fall", {31'b0, bus.irq_rv}, 32'd0);

    // HPS doorbell follows the state of the r2h FIFO.
    addVec(0, 1, 3, 32'h1, 4'h0, 0, 0, "hps irqen set");
    addVec(1, 1, 0, 32'h2222_0001, 4'hF, 0, 0, "rv push irq word");
    runTable();
    checkOutput("irq_hps rise", {31'b0, bus.irq_hps}, {31'b0, IRQV});
    addVec(0, 0, 1, 0, 4'h0, 0, 0, "hps pop irq word");
    runTable();
    @(negedge clk);
    checkOutput("irq_hps hold", {31'b0, bus.irq_hps}, {31'b0, IRQV});
    @(negedge clk);
    checkOutput("irq_hps fall", {31'b0, bus.irq_hps}, 32'd0);

    // Reset while a CPU read response is pending.
    apbXfer(1'b1, 4'h0, 32'h3333_0001, rd, err);
    @(posedge clk); #1;
    bus.mem_valid = 1'b1; bus.rv_sel = 1'b1; bus.mem_addr = 4'h4; bus.mem_wstrb = 4'h0;
    @(posedge clk); #1;
    checkOutput("midrst ready before", {31'b0, bus.mem_ready}, 32'd1);
    checkOutput("midrst rdata before", bus.mem_rdata, 32'h3333_0001);
    resetn = 1'b0;
    #1;
    checkOutput("midrst ready", {31'b0, bus.mem_ready}, 32'd0);
    checkOutput("midrst rdata", bus.mem_rdata, 32'd0);
    bus.mem_valid = 1'b0; bus.rv_sel = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    h2rQ.delete();
    r2hQ.delete();
    addVec(0, 0, 2, 0, 4'h0, 32'h0000_000A, 0, "midrst hps status");
    addVec(1, 0, 2, 0, 4'h0, 32'h0000_000A, 0, "midrst rv status");
    addVec(1, 0, 3, 0, 4'h0, 32'h0, 0, "midrst rv irqen");
    runTable();

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
